pong_match_ctrl: RTL and testbench

Match sequencer for the Pong datapath: owns game flow (ready, settings menu, serve, rally, game-over), the score registers, the per-match countdown and the configurable parameters (win score, ball speed, time limit). Sits between the debounced/one-pulsed player buttons and the ball, paddle and pixel-generation blocks. It replaces ad-hoc state and score logic in the top level with one registered FSM clocked on the 25 MHz pixel clock.

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/pong_match_ctrl_if.sv | 45 ++++
 rtl/pong_frame_counter.sv | 29 ++
 rtl/pong_match_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: state encodings, menu field codes, setting limits/defaults, winner codes.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_SETTING   = 3'd1,
    ST_SERVE     = 3'd2,
    ST_PLAY      = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] SEL_WIN_SCORE  = 2'd0;
  localparam logic [1:0] SEL_BALL_SPEED = 2'd1;
  localparam logic [1:0] SEL_TIME_LIMIT = 2'd2;

  localparam logic [3:0] WIN_SCORE_MIN  = 4'd1;
  localparam logic [3:0] WIN_SCORE_MAX  = 4'd9;
  localparam logic [3:0] WIN_SCORE_DEF  = 4'd5;

  localparam logic [3:0] BALL_SPEED_MIN = 4'd1;
  localparam logic [3:0] BALL_SPEED_MAX = 4'd15;
  localparam logic [3:0] BALL_SPEED_DEF = 4'd2;

  localparam logic [6:0] TIME_LIMIT_MIN  = 7'd10;
  localparam logic [6:0] TIME_LIMIT_MAX  = 7'd90;
  localparam logic [6:0] TIME_LIMIT_STEP = 7'd10;
  localparam logic [6:0] TIME_LIMIT_DEF  = 7'd60;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Winner of a match that ended on the clock rather than on points.
  function automatic logic [1:0] judge_timeout(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Bundle between the match sequencer and the button/ball/pixel blocks.
// Latency: n/a (wires only).
// Backpressure: none; all signals are pulses or levels.
// Ports: inputs refresh_tick, up/down button pulses, ball_out_*; outputs game
//   state, settings, countdown, scores, new_round, ball_run, game_over, winner.
interface pong_match_ctrl_if;

  logic       refresh_tick;
  logic       up1_pulse;
  logic       down1_pulse;
  logic       up2_pulse;
  logic       down2_pulse;
  logic       ball_out_left;
  logic       ball_out_right;

  logic [2:0] state;
  logic [1:0] setting_sel;
  logic [3:0] win_score;
  logic [3:0] ball_speed;
  logic [6:0] time_limit;
  logic [6:0] seconds;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       new_round;
  logic       ball_run;
  logic       game_over;
  logic [1:0] winner;

  // master: the match sequencer itself
  modport master (
    input  refresh_tick, up1_pulse, down1_pulse, up2_pulse, down2_pulse,
           ball_out_left, ball_out_right,
    output state, setting_sel, win_score, ball_speed, time_limit, seconds,
           score1, score2, new_round, ball_run, game_over, winner
  );

  // slave: datapath side that feeds events in and consumes game status
  modport slave (
    output refresh_tick, up1_pulse, down1_pulse, up2_pulse, down2_pulse,
           ball_out_left, ball_out_right,
    input  state, setting_sel, win_score, ball_speed, time_limit, seconds,
           score1, score2, new_round, ball_run, game_over, winner
  );

endinterface

// File: rtl/pong_frame_counter.sv
// Counts refresh ticks; done fires on the tick that reaches terminal, then wraps.
// Latency: done is combinational on the terminal tick; count updates next edge.
// Backpressure: none.
// Ports: clk, reset (sync, high), clear (sync), tick, terminal -> done.
module pong_frame_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // terminal counts ticks, so the last tick is seen while count == terminal-1
  assign done = tick && (count == terminal - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= done ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: game flow, scores, countdown and menu settings for Pong.
// Latency: every output is registered; inputs act on the next clock edge.
// Backpressure: none; button and tick pulses are consumed in the cycle they arrive.
// Ports: clk, reset (sync, high), bus (pong_match_ctrl_if.master).
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int SERVE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic                clk,
  input  logic                reset,
  pong_match_ctrl_if.master   bus
);

  state_t     state_q, state_n;
  logic [1:0] sel_q, sel_n;
  logic [3:0] win_score_q, win_score_n;
  logic [3:0] ball_speed_q, ball_speed_n;
  logic [6:0] time_limit_q, time_limit_n;
  logic [6:0] seconds_q, seconds_n;
  logic [3:0] score1_q, score1_n;
  logic [3:0] score2_q, score2_n;
  logic [1:0] winner_q, winner_n;
  logic       new_round_q, new_round_n;
  logic       ball_run_q, ball_run_n;
  logic       game_over_q, game_over_n;

  logic       fc_clear;
  logic       fc_done;
  logic [7:0] fc_terminal;
  logic       scored;
  logic       win_by_score;
  logic       timeout;

  // One counter serves all three intervals; which one depends on the state.
  always_comb begin
    fc_terminal = 8'(FRAMES_PER_SEC);
    case (state_q)
      ST_SERVE:     fc_terminal = 8'(SERVE_FRAMES);
      ST_GAME_OVER: fc_terminal = 8'(GAMEOVER_FRAMES);
      default:      fc_terminal = 8'(FRAMES_PER_SEC);
    endcase
  end

  pong_frame_counter #(.WIDTH(8)) u_frame_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (fc_clear),
    .tick     (bus.refresh_tick),
    .terminal (fc_terminal),
    .done     (fc_done)
  );

  always_comb begin
    state_n      = state_q;
    sel_n        = sel_q;
    win_score_n  = win_score_q;
    ball_speed_n = ball_speed_q;
    time_limit_n = time_limit_q;
    seconds_n    = seconds_q;
    score1_n     = score1_q;
    score2_n     = score2_q;
    winner_n     = winner_q;
    scored       = 1'b0;
    win_by_score = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      ST_READY: begin
        if (bus.up1_pulse) begin
          score1_n  = '0;
          score2_n  = '0;
          winner_n  = WIN_NONE;
          seconds_n = time_limit_q;
          state_n   = ST_SERVE;
        end else if (bus.down1_pulse) begin
          state_n = ST_SETTING;
        end
      end

      ST_SETTING: begin
        if (bus.down2_pulse) begin
          sel_n     = SEL_WIN_SCORE;
          seconds_n = time_limit_q;
          state_n   = ST_READY;
        end else if (bus.up2_pulse) begin
          sel_n = (sel_q == SEL_TIME_LIMIT) ? SEL_WIN_SCORE : sel_q + 2'd1;
        end else if (bus.up1_pulse) begin
          case (sel_q)
            SEL_WIN_SCORE:
              if (win_score_q < WIN_SCORE_MAX) win_score_n = win_score_q + 4'd1;
            SEL_BALL_SPEED:
              if (ball_speed_q < BALL_SPEED_MAX) ball_speed_n = ball_speed_q + 4'd1;
            default:
              time_limit_n = (time_limit_q <= TIME_LIMIT_MAX - TIME_LIMIT_STEP)
                           ? time_limit_q + TIME_LIMIT_STEP : TIME_LIMIT_MAX;
          endcase
        end else if (bus.down1_pulse) begin
          case (sel_q)
            SEL_WIN_SCORE:
              if (win_score_q > WIN_SCORE_MIN) win_score_n = win_score_q - 4'd1;
            SEL_BALL_SPEED:
              if (ball_speed_q > BALL_SPEED_MIN) ball_speed_n = ball_speed_q - 4'd1;
            default:
              time_limit_n = (time_limit_q >= TIME_LIMIT_MIN + TIME_LIMIT_STEP)
                           ? time_limit_q - TIME_LIMIT_STEP : TIME_LIMIT_MIN;
          endcase
        end
      end

      ST_SERVE: begin
        if (fc_done) state_n = ST_PLAY;
      end

      ST_PLAY: begin
        // Left exit wins a tie with a simultaneous right exit.
        if (bus.ball_out_left) begin
          score2_n = score2_q + 4'd1;
          scored   = 1'b1;
          if (score2_n == win_score_q) begin
            win_by_score = 1'b1;
            winner_n     = WIN_P2;
          end
        end else if (bus.ball_out_right) begin
          score1_n = score1_q + 4'd1;
          scored   = 1'b1;
          if (score1_n == win_score_q) begin
            win_by_score = 1'b1;
            winner_n     = WIN_P1;
          end
        end

        if (fc_done && (seconds_q != 7'd0)) begin
          seconds_n = seconds_q - 7'd1;
          timeout   = (seconds_q == 7'd1);
        end

        // Points are applied before the clock is judged.
        if (win_by_score) begin
          state_n = ST_GAME_OVER;
        end else if (timeout) begin
          winner_n = judge_timeout(score1_n, score2_n);
          state_n  = ST_GAME_OVER;
        end else if (scored) begin
          state_n = ST_SERVE;
        end
      end

      ST_GAME_OVER: begin
        if (fc_done) state_n = ST_READY;
      end

      default: state_n = ST_READY;
    endcase

    fc_clear    = (state_n != state_q);
    new_round_n = (state_n == ST_SERVE) && (state_q != ST_SERVE);
    ball_run_n  = (state_n == ST_PLAY);
    game_over_n = (state_n == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_READY;
      sel_q        <= SEL_WIN_SCORE;
      win_score_q  <= WIN_SCORE_DEF;
      ball_speed_q <= BALL_SPEED_DEF;
      time_limit_q <= TIME_LIMIT_DEF;
      seconds_q    <= TIME_LIMIT_DEF;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= WIN_NONE;
      new_round_q  <= 1'b0;
      ball_run_q   <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      sel_q        <= sel_n;
      win_score_q  <= win_score_n;
      ball_speed_q <= ball_speed_n;
      time_limit_q <= time_limit_n;
      seconds_q    <= seconds_n;
      score1_q     <= score1_n;
      score2_q     <= score2_n;
      winner_q     <= winner_n;
      new_round_q  <= new_round_n;
      ball_run_q   <= ball_run_n;
      game_over_q  <= game_over_n;
    end
  end

  assign bus.state       = state_q;
  assign bus.setting_sel = sel_q;
  assign bus.win_score   = win_score_q;
  assign bus.ball_speed  = ball_speed_q;
  assign bus.time_limit  = time_limit_q;
  assign bus.seconds     = seconds_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.new_round   = new_round_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a queue of expected field values.
// Latency: checks sample 1 time unit after each active edge.
// Backpressure: n/a.
module tb_pong_match_ctrl;

  localparam int F_STATE = 0, F_SEL = 1, F_WIN = 2, F_SPEED = 3, F_TLIM = 4,
                 F_SEC = 5, F_S1 = 6, F_S2 = 7, F_NR = 8, F_RUN = 9,
                 F_GO = 10, F_WINNER = 11;

  typedef struct {
    string tag;
    int    field;
    int    value;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   vectors;
  int   miscompares;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .FRAMES_PER_SEC  (2),
    .SERVE_FRAMES    (3),
    .GAMEOVER_FRAMES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, vectors=%0d required=finish", vectors);
    $fatal(1, "watchdog expired");
  end

  function automatic int observe(input int field);
    case (field)
      F_STATE:  return int'(bus.state);
      F_SEL:    return int'(bus.setting_sel);
      F_WIN:    return int'(bus.win_score);
      F_SPEED:  return int'(bus.ball_speed);
      F_TLIM:   return int'(bus.time_limit);
      F_SEC:    return int'(bus.seconds);
      F_S1:     return int'(bus.score1);
      F_S2:     return int'(bus.score2);
      F_NR:     return int'(bus.new_round);
      F_RUN:    return int'(bus.ball_run);
      F_GO:     return int'(bus.game_over);
      default:  return int'(bus.winner);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int field, input int value);
    exp_t e;
    e.tag = tag; e.field = field; e.value = value;
    sb.push_back(e);
  endtask

  // Pops every pending expectation and compares it with the sampled outputs.
  task automatic check();
    exp_t e;
    int   obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.field);
      vectors++;
      assert (obs === e.value) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge take them, then release.
  task automatic apply(input logic u1, input logic d1, input logic u2, input logic d2,
                       input logic l, input logic r, input logic tk);
    bus.up1_pulse = u1; bus.down1_pulse = d1;
    bus.up2_pulse = u2; bus.down2_pulse = d2;
    bus.ball_out_left = l; bus.ball_out_right = r;
    bus.refresh_tick = tk;
    @(posedge clk); #1;
    bus.up1_pulse = 0; bus.down1_pulse = 0; bus.up2_pulse = 0; bus.down2_pulse = 0;
    bus.ball_out_left = 0; bus.ball_out_right = 0; bus.refresh_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.up1_pulse = 0; bus.down1_pulse = 0; bus.up2_pulse = 0; bus.down2_pulse = 0;
    bus.ball_out_left = 0; bus.ball_out_right = 0; bus.refresh_tick = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    expect_val("rst_state", F_STATE, 0);  expect_val("rst_sel", F_SEL, 0);
    expect_val("rst_win", F_WIN, 5);      expect_val("rst_speed", F_SPEED, 2);
    expect_val("rst_tlim", F_TLIM, 60);   expect_val("rst_sec", F_SEC, 60);
    expect_val("rst_s1", F_S1, 0);        expect_val("rst_s2", F_S2, 0);
    expect_val("rst_nr", F_NR, 0);        expect_val("rst_run", F_RUN, 0);
    expect_val("rst_go", F_GO, 0);        expect_val("rst_winner", F_WINNER, 0);
    check();

    // Start: SERVE with a one-cycle new_round, then PLAY after 3 ticks
    apply(1, 0, 0, 0, 0, 0, 0);
    expect_val("start_state", F_STATE, 2); expect_val("start_nr", F_NR, 1);
    check();
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_val("serve_nr_drop", F_NR, 0);  expect_val("serve_run", F_RUN, 0);
    check();
    ticks(2);
    expect_val("serve_hold", F_STATE, 2);
    check();
    ticks(1);
    expect_val("play_state", F_STATE, 3);  expect_val("play_run", F_RUN, 1);
    expect_val("play_sec", F_SEC, 60);
    check();

    // Right exit held 5 cycles scores once
    bus.ball_out_right = 1;
    @(posedge clk); #1;
    expect_val("rexit_s1", F_S1, 1);       expect_val("rexit_state", F_STATE, 2);
    expect_val("rexit_nr", F_NR, 1);
    check();
    repeat (4) @(posedge clk);
    #1 bus.ball_out_right = 0;
    expect_val("rexit_held_s1", F_S1, 1);  expect_val("rexit_held_state", F_STATE, 2);
    check();

    // Build score1=3 in PLAY, let a second elapse, then reset mid-match
    ticks(3);
    apply(0, 0, 0, 0, 0, 1, 0);
    ticks(3);
    apply(0, 0, 0, 0, 0, 1, 0);
    ticks(3);
    expect_val("pre_rst_s1", F_S1, 3);     expect_val("pre_rst_state", F_STATE, 3);
    check();
    ticks(2);
    expect_val("pre_rst_sec", F_SEC, 59);
    check();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_val("mid_rst_state", F_STATE, 0); expect_val("mid_rst_s1", F_S1, 0);
    expect_val("mid_rst_sec", F_SEC, 60);    expect_val("mid_rst_run", F_RUN, 0);
    check();

    // win_score 5 -> 2 through the menu
    apply(0, 1, 0, 0, 0, 0, 0);
    expect_val("menu_state", F_STATE, 1);
    check();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0);
      expect_val("menu_win_dec", F_WIN, 4 - i);
      check();
    end
    apply(0, 0, 0, 1, 0, 0, 0);
    expect_val("menu_exit_state", F_STATE, 0);
    check();

    // Two left exits end the match for player 2
    apply(1, 0, 0, 0, 0, 0, 0);
    ticks(3);
    apply(0, 0, 0, 0, 1, 0, 0);
    expect_val("lexit1_s2", F_S2, 1);      expect_val("lexit1_state", F_STATE, 2);
    check();
    ticks(3);
    apply(0, 0, 0, 0, 1, 0, 0);
    expect_val("lexit2_s2", F_S2, 2);      expect_val("win2_state", F_STATE, 4);
    expect_val("win2_winner", F_WINNER, 2); expect_val("win2_go", F_GO, 1);
    expect_val("win2_run", F_RUN, 0);
    check();
    apply(1, 0, 0, 0, 0, 0, 1);
    ticks(2);
    expect_val("go_hold_state", F_STATE, 4); expect_val("go_hold_s2", F_S2, 2);
    check();
    ticks(1);
    expect_val("go_exit_state", F_STATE, 0); expect_val("go_exit_winner", F_WINNER, 2);
    check();

    // time_limit 60 -> 10, then saturate at 10
    apply(0, 1, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    expect_val("sel_tlim", F_SEL, 2);
    check();
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0, 0, 0);
    expect_val("tlim_10", F_TLIM, 10);
    check();
    apply(0, 1, 0, 0, 0, 0, 0);
    expect_val("tlim_sat_lo", F_TLIM, 10);
    check();
    apply(0, 0, 1, 1, 0, 0, 0);
    expect_val("exit_prio_state", F_STATE, 0); expect_val("exit_sel", F_SEL, 0);
    expect_val("exit_sec", F_SEC, 10);
    check();

    // Timed match with no exits: draw
    apply(1, 0, 0, 0, 0, 0, 0);
    expect_val("tm_winner_clr", F_WINNER, 0); expect_val("tm_s2_clr", F_S2, 0);
    check();
    ticks(3);
    ticks(19);
    expect_val("tm_sec1", F_SEC, 1);       expect_val("tm_state_play", F_STATE, 3);
    check();
    ticks(1);
    expect_val("tm_sec0", F_SEC, 0);       expect_val("tm_state_go", F_STATE, 4);
    expect_val("tm_draw", F_WINNER, 3);
    check();
    ticks(4);

    // Timeout coinciding with a right exit
    apply(1, 0, 0, 0, 0, 0, 0);
    ticks(3);
    ticks(19);
    apply(0, 0, 0, 0, 0, 1, 1);
    expect_val("tmr_s1", F_S1, 1);         expect_val("tmr_state", F_STATE, 4);
    expect_val("tmr_winner", F_WINNER, 1); expect_val("tmr_sec", F_SEC, 0);
    check();
    ticks(4);
    expect_val("tmr_ready", F_STATE, 0);
    check();

    // ball_speed saturates high; setting_sel wraps
    apply(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, 0, 0, 0);
      expect_val("sel_wrap", F_SEL, (i + 1) % 3);
      check();
    end
    apply(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) apply(1, 0, 0, 0, 0, 0, 0);
    expect_val("speed_sat_hi", F_SPEED, 15); expect_val("speed_win_kept", F_WIN, 2);
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
